// File: rtl/ttl_shift_plane.sv
// Purpose: CHANNELS lock-step universal shift registers, WIDTH bits each, with per-channel
//          holding registers that reload automatically when the shared bit counter wraps.
// Latency: the registers update on the clk edge when cen=1; qout follows sr and flip with no delay.
// Backpressure: none. load_req pulses on each counter wrap; underrun latches a wrap that
//               found no holding data, and only a parallel load clears it.
// Ports: clk/n_clr (async active-low); cen, mode, flip, din, dsl, dsr, hold_wr inputs;
//        qout (tap per channel), q_all (packed sr), bit_cnt, load_req, underrun outputs.
module ttl_shift_plane #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 3,
    parameter bit AUTO_RELOAD = 1'b1,
    localparam int CW         = $clog2(WIDTH)
) (
    input  logic                      clk,
    input  logic                      n_clr,
    input  logic                      cen,
    input  logic [1:0]                mode,
    input  logic                      flip,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       dsl,
    input  logic [CHANNELS-1:0]       dsr,
    input  logic                      hold_wr,
    output logic [CHANNELS-1:0]       qout,
    output logic [CHANNELS*WIDTH-1:0] q_all,
    output logic [CW-1:0]             bit_cnt,
    output logic                      load_req,
    output logic                      underrun
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_RIGHT = 2'b01;
    localparam logic [1:0] M_LEFT  = 2'b10;
    localparam logic [1:0] M_LOAD  = 2'b11;

    logic [CHANNELS*WIDTH-1:0] sr_q, sr_d;
    logic [CHANNELS*WIDTH-1:0] hold_q, hold_d;
    logic [CHANNELS*WIDTH-1:0] shifted;
    logic                      hold_valid_q, hold_valid_d;
    logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
    logic                      load_req_q, load_req_d;
    logic                      underrun_q, underrun_d;

    // Per-channel single-step shift in the direction selected by mode.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (mode == M_RIGHT) begin
                shifted[c*WIDTH +: WIDTH] = {dsl[c], sr_q[c*WIDTH+1 +: WIDTH-1]};
            end else begin
                shifted[c*WIDTH +: WIDTH] = {sr_q[c*WIDTH +: WIDTH-1], dsr[c]};
            end
        end
    end

    always_comb begin
        sr_d         = sr_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_cnt_d    = bit_cnt_q;
        load_req_d   = 1'b0;
        underrun_d   = underrun_q;

        // The holding register accepts writes regardless of cen and mode.
        if (hold_wr) begin
            hold_d       = din;
            hold_valid_d = 1'b1;
        end

        if (cen) begin
            case (mode)
                M_LOAD: begin
                    sr_d       = din;
                    bit_cnt_d  = '0;
                    underrun_d = 1'b0;
                end
                M_RIGHT, M_LEFT: begin
                    sr_d = shifted;
                    if (bit_cnt_q != LAST) begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end else begin
                        bit_cnt_d  = '0;
                        load_req_d = 1'b1;
                        if (AUTO_RELOAD) begin
                            if (hold_valid_q) begin
                                // Consume the held word; a same-cycle write refills it.
                                sr_d         = hold_q;
                                hold_valid_d = hold_wr;
                            end else if (hold_wr) begin
                                // Data arrives just in time: load it straight through
                                // and leave the holding register marked empty.
                                sr_d         = din;
                                hold_valid_d = 1'b0;
                            end else begin
                                underrun_d = 1'b1;
                            end
                        end
                    end
                end
                M_HOLD:  ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            sr_q         <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            load_req_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bit_cnt_q    <= bit_cnt_d;
            load_req_q   <= load_req_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        qout = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            qout[c] = flip ? sr_q[c*WIDTH + WIDTH-1] : sr_q[c*WIDTH];
        end
    end

    assign q_all    = sr_q;
    assign bit_cnt  = bit_cnt_q;
    assign load_req = load_req_q;
    assign underrun = underrun_q;

endmodule

// File: doc/ttl_shift_plane.md
Name: ttl_shift_plane

Overview:
- Parametrised successor to the discrete 74LS194/299/166 shifter models: CHANNELS parallel universal shift registers, each WIDTH bits wide, sharing one mode, clock enable and bit counter.
- Adds a per-channel holding register with automatic reload every WIDTH shifts, a reload-request pulse and a sticky underrun flag.
- Sits in the video path between tile/sprite ROM fetch and pixel mux. Replaces chains of ls166x3-style shifters plus external load-timing logic.

Parameters:
- WIDTH, 8, bits per channel shift register (>=2).
- CHANNELS, 3, number of bit-planes shifted in lock-step (>=1).
- AUTO_RELOAD, 1, 1 = reload from holding register on counter wrap; 0 = counter wraps with no reload and no underrun.
- CW, $clog2(WIDTH), bit counter width (derived, not overridden).

Ports:
- clk, in, 1, single system clock, posedge.
- n_clr, in, 1, asynchronous active-low reset.
- cen, in, 1, pixel clock enable; shift/load/hold actions only when 1.
- mode, in, 2, 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- flip, in, 1, output tap select: 0 = bit 0, 1 = bit WIDTH-1.
- din, in, CHANNELS*WIDTH, packed parallel data; channel c at [c*WIDTH +: WIDTH].
- dsl, in, CHANNELS, serial input entering at MSB on shift right.
- dsr, in, CHANNELS, serial input entering at LSB on shift left.
- hold_wr, in, 1, write din into holding registers; independent of cen.
- qout, out, CHANNELS, per-channel tap (combinational from sr and flip).
- q_all, out, CHANNELS*WIDTH, packed shift register contents.
- bit_cnt, out, CW, shifts since last load/reload.
- load_req, out, 1, one-clk pulse on counter wrap.
- underrun, out, 1, sticky: a wrap occurred with no valid holding data.

Behaviour:
- Reset (n_clr=0, async): sr, hold, hold_valid, bit_cnt, load_req and underrun all 0. qout = 0 and q_all = 0.
- qout[c] = flip ? sr[c][WIDTH-1] : sr[c][0]. It is purely combinational, so there is zero latency from a flip change.
- Holding register: hold_wr=1 at posedge writes hold <= din and sets hold_valid <= 1, regardless of cen and mode.
- When cen=0:
  - sr and bit_cnt are frozen.
  - load_req <= 0.
  - underrun is unchanged.
- When cen=1, mode 00: sr and bit_cnt are unchanged; load_req <= 0.
- When cen=1, mode 11:
  - sr <= din and bit_cnt <= 0.
  - underrun <= 0 (this is the only non-reset clear).
  - load_req <= 0.
  - hold and hold_valid are unaffected, except by hold_wr in the same cycle.
- When cen=1, mode 01: sr[c] <= {dsl[c], sr[c][WIDTH-1:1]}.
- When cen=1, mode 10: sr[c] <= {sr[c][WIDTH-2:0], dsr[c]}.
- Shift modes, bit_cnt < WIDTH-1: bit_cnt <= bit_cnt+1 and load_req <= 0.
- Shift modes, bit_cnt == WIDTH-1 (wrap): bit_cnt <= 0 and load_req <= 1 for exactly one clk. Then, with AUTO_RELOAD=1:
  - hold_valid=1: sr <= hold (replaces the shifted value) and hold_valid <= 0. If hold_wr is also active, hold <= din and hold_valid stays 1.
  - hold_valid=0, hold_wr=1: bypass, sr <= din, hold_valid stays 0, no underrun.
  - hold_valid=0, hold_wr=0: the normal shift is applied and underrun <= 1.
- AUTO_RELOAD=0: a wrap performs the normal shift and pulses load_req. hold is never consumed and underrun stays 0.
- Mode change mid-word: bit_cnt continues counting and is not reset. Only mode 11 or reset zeroes it.
- Reset asserted mid-word: all state clears immediately. The first shift after release counts from 0.
- One shared counter for all channels; all channels shift, load and reload in the same cycle.

Test Plan:
- Reset: hold n_clr=0 with random inputs. Require q_all=0, qout=0, bit_cnt=0, load_req=0, underrun=0. Release, then mode=00 with cen=1 for 5 clks; all outputs stay 0.
- Load/shift right, WIDTH=8, CHANNELS=3, flip=0:
  - Stimulus: mode=11 with din={8'hF0,8'h0F,8'hA5}, then mode=01, dsl=0.
  - Required: ch0 qout sequence 1,0,1,0,0,1,0,1.
  - Required: bit_cnt 1..7 then 0, with load_req high only on the clk after the 8th shift.
- Auto reload:
  - Stimulus: mode=11 with din ch0=8'h01; hold_wr with ch0=8'h80; shift left 8 times with flip=1.
  - Required: after wrap, sr ch0=8'h80, hold_valid=0, underrun=0, and next qout ch0=1.
- Underrun and clear:
  - Stimulus: shift 8 with no hold_wr.
  - Required: underrun=1 and sr equals the plain shifted value.
  - Further shifts keep underrun=1. A mode=11 load clears it to 0.
- Simultaneous wrap and hold_wr with hold_valid=0: require the bypass load sr=din, hold_valid=0, underrun=0.
- cen gating: with cen toggling 1,0,1,0 in mode 01, require sr and bit_cnt to advance only on cen=1. A hold_wr during cen=0 must still set hold_valid.
